// File: rtl/jtsbaskt_obj_linebuf.sv
// Sprite line buffer: scans object RAM for the next line, fetches 16x16 4bpp rows from ROM
// and paints one half of a double line buffer while the other half is read out and cleared.
//
// state | meaning
// IDLE  | waiting for the first line start
// READ  | fetching the 4 bytes of the current sprite entry
// CHECK | vertical hit test against the next line
// FETCH | ROM request for one 8-pixel half row
// DRAW  | painting 8 pixels, one per clk
// DONE  | all sprites scanned, waiting for line start
module jtsbaskt_obj_linebuf #(
   parameter int         OBJMAX  = 24,
   parameter logic [7:0] HOFFSET = 8'd0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pxl_cen,
   input  logic        hs,
   input  logic        LHBL,
   input  logic [7:0]  vdump,
   input  logic [7:0]  hdump,
   input  logic        flip,
   output logic [7:0]  oram_addr,
   input  logic [7:0]  oram_dout,
   output logic [13:0] rom_addr,
   output logic        rom_cs,
   input  logic        rom_ok,
   input  logic [31:0] rom_data,
   output logic [3:0]  obj_pxl
);
   typedef enum logic [2:0] {IDLE, READ, CHECK, FETCH, DRAW, DONE} state_t;

   localparam logic [5:0] LAST_IDX = 6'(OBJMAX - 1);

   state_t      state, state_nxt;
   logic [5:0]  idx;
   logic [2:0]  rd_cnt;
   logic [7:0]  code_lo, spr_x, spr_y;
   logic        code_hi, hflip, vflip;
   logic [3:0]  row;
   logic        pass;
   logic [2:0]  pix_cnt;
   logic [31:0] pxl_word;
   logic        draw_bank;
   logic [7:0]  clr_cnt;
   logic        clr_busy;
   logic [3:0]  mem0 [0:255];
   logic [3:0]  mem1 [0:255];

   logic [7:0]  ydiff_now;
   logic        miss, last_spr;
   logic [2:0]  nib_sel;
   logic [3:0]  draw_nib;
   logic [7:0]  draw_addr, rd_addr;
   logic        draw_we, rd_clr;

   assign ydiff_now = vdump + 8'd1 - spr_y;
   assign miss      = ydiff_now[7:4] != 4'd0;
   assign last_spr  = idx == LAST_IDX;

   assign oram_addr = {idx, rd_cnt[1:0]};
   assign rom_cs    = state == FETCH;
   assign rom_addr  = {code_hi, code_lo, row, pass ^ hflip};

   // hflip walks the word from its low nibble upwards
   assign nib_sel   = hflip ? pix_cnt : ~pix_cnt;
   assign draw_nib  = pxl_word[{nib_sel, 2'b00} +: 4];
   assign draw_addr = spr_x + {4'd0, pass, pix_cnt};
   assign draw_we   = state == DRAW && draw_nib != 4'd0;

   assign rd_addr   = (flip ? ~hdump : hdump) + HOFFSET;
   assign rd_clr    = pxl_cen && LHBL && !clr_busy;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (hs) begin
         state_nxt = READ;
      end else begin
         case (state)
            IDLE:  state_nxt = IDLE;
            READ:  if (rd_cnt == 3'd4) state_nxt = CHECK;
            CHECK: begin
               if (!miss)         state_nxt = FETCH;
               else if (last_spr) state_nxt = DONE;
               else               state_nxt = READ;
            end
            FETCH: if (rom_ok) state_nxt = DRAW;
            DRAW: begin
               if (pix_cnt == 3'd7) begin
                  if (!pass)         state_nxt = FETCH;
                  else if (last_spr) state_nxt = DONE;
                  else               state_nxt = READ;
               end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         draw_bank <= 1'b0;
         idx       <= 6'd0;
         rd_cnt    <= 3'd0;
         code_lo   <= 8'd0;
         code_hi   <= 1'b0;
         hflip     <= 1'b0;
         vflip     <= 1'b0;
         spr_x     <= 8'd0;
         spr_y     <= 8'd0;
         row       <= 4'd0;
         pass      <= 1'b0;
         pix_cnt   <= 3'd0;
         pxl_word  <= 32'd0;
      end else if (hs) begin
         draw_bank <= ~draw_bank;
         idx       <= 6'd0;
         rd_cnt    <= 3'd0;
      end else begin
         case (state)
            READ: begin
               // oram_dout lags oram_addr by one clk, so byte k lands when rd_cnt is k+1
               rd_cnt <= rd_cnt + 3'd1;
               case (rd_cnt)
                  3'd1: code_lo <= oram_dout;
                  3'd2: begin
                     code_hi <= oram_dout[0];
                     hflip   <= oram_dout[6];
                     vflip   <= oram_dout[7];
                  end
                  3'd3: spr_x <= oram_dout;
                  3'd4: spr_y <= oram_dout;
                  default: ;
               endcase
            end
            CHECK: begin
               rd_cnt <= 3'd0;
               pass   <= 1'b0;
               row    <= vflip ? ~ydiff_now[3:0] : ydiff_now[3:0];
               if (miss && !last_spr) idx <= idx + 6'd1;
            end
            FETCH: begin
               if (rom_ok) begin
                  pxl_word <= rom_data;
                  pix_cnt  <= 3'd0;
               end
            end
            DRAW: begin
               pix_cnt <= pix_cnt + 3'd1;
               if (pix_cnt == 3'd7) begin
                  if (!pass)          pass <= 1'b1;
                  else if (!last_spr) idx  <= idx + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_busy <= 1'b1;
         clr_cnt  <= 8'd0;
      end else if (clr_busy) begin
         clr_cnt <= clr_cnt + 8'd1;
         if (clr_cnt == 8'hff) clr_busy <= 1'b0;
      end
   end

   // draw and read/clear always target opposite halves
   always_ff @(posedge clk) begin
      if (clr_busy) begin
         mem0[clr_cnt] <= 4'd0;
         mem1[clr_cnt] <= 4'd0;
      end else begin
         if (draw_we) begin
            if (draw_bank) mem1[draw_addr] <= draw_nib;
            else           mem0[draw_addr] <= draw_nib;
         end
         if (rd_clr) begin
            if (draw_bank) mem0[rd_addr] <= 4'd0;
            else           mem1[rd_addr] <= 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         obj_pxl <= 4'd0;
      end else if (pxl_cen) begin
         if (rd_clr) obj_pxl <= draw_bank ? mem0[rd_addr] : mem1[rd_addr];
         else        obj_pxl <= 4'd0;
      end
   end
endmodule

// File: tb/tb_jtsbaskt_obj_linebuf.sv
// Line-based bench: each line paints a reference image from the sprite table and
// expects it back on the next line's readout; ROM requests and pixels go through scoreboards.
module tb_jtsbaskt_obj_linebuf;
   localparam int OBJMAX = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pxl_cen = 1'b0, hs = 1'b0, LHBL = 1'b0, flip = 1'b0;
   logic [7:0]  vdump = 8'h10, hdump = 8'h00;
   logic [7:0]  oram_addr, oram_dout = 8'h00;
   logic [13:0] rom_addr;
   logic        rom_cs, rom_ok = 1'b0;
   logic [31:0] rom_data = 32'h0;
   logic [3:0]  obj_pxl;

   jtsbaskt_obj_linebuf #(.OBJMAX(OBJMAX), .HOFFSET(8'd0)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hs(hs), .LHBL(LHBL),
      .vdump(vdump), .hdump(hdump), .flip(flip),
      .oram_addr(oram_addr), .oram_dout(oram_dout),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
      .obj_pxl(obj_pxl)
   );

   always #5 clk = ~clk;

   int          total = 0, bad = 0;
   logic [7:0]  oram [256];
   logic [31:0] rom_mem [16384];
   int          rom_lat = 0, rom_wait = 0;
   bit          rom_stall = 0, prev_cs = 0;
   logic [3:0]  exp_pix [$];
   logic [13:0] exp_rom [$];
   logic [3:0]  img_cur [256];
   logic [3:0]  img_next [256];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) oram_dout <= oram[oram_addr];

   // ROM model and request scoreboard
   always @(posedge clk) begin
      #1;
      if (rst) begin
         rom_ok = 0; rom_wait = 0; prev_cs = 0;
      end else begin
         if (rom_cs && !prev_cs) begin
            if (exp_rom.size() == 0) begin
               total++; bad++;
               $display("FAIL rom_unexpected: request %0h with none expected", rom_addr);
            end else begin
               check("rom_addr", int'(rom_addr), int'(exp_rom.pop_front()));
            end
         end
         prev_cs = rom_cs;
         if (rom_cs && !rom_stall) begin
            if (rom_wait >= rom_lat) begin
               rom_ok = 1; rom_data = rom_mem[rom_addr];
            end else begin
               rom_wait++; rom_ok = 0;
            end
         end else begin
            rom_ok = 0; rom_wait = 0;
         end
      end
   end

   // pixel scoreboard
   always @(posedge clk) begin
      if (!rst && pxl_cen) begin
         #1;
         if (exp_pix.size() == 0) begin
            total++; bad++;
            $display("FAIL pixel_unexpected: obj_pxl=%0h with none expected", obj_pxl);
         end else begin
            check("obj_pxl", int'(obj_pxl), int'(exp_pix.pop_front()));
         end
      end
   end

   // reference painter: sprites in index order, later ones on top
   task automatic model_line(input int max_fetch);
      int nf, x, y, yd, row, half, nib, pix;
      logic [8:0]  code;
      logic [13:0] a;
      bit hf, vf;
      nf = 0;
      foreach (img_next[i]) img_next[i] = 4'd0;
      for (int s = 0; s < OBJMAX; s++) begin
         code = {oram[s*4+1][0], oram[s*4]};
         hf   = oram[s*4+1][6];
         vf   = oram[s*4+1][7];
         x    = int'(oram[s*4+2]);
         y    = int'(oram[s*4+3]);
         yd   = (int'(vdump) + 1 - y) & 255;
         if (yd < 16) begin
            row = vf ? 15 - yd : yd;
            for (int ps = 0; ps < 2; ps++) begin
               half = ps ^ int'(hf);
               a    = 14'(int'(code) * 32 + row * 2 + half);
               if (nf < max_fetch) exp_rom.push_back(a);
               nf++;
               for (int p = 0; p < 8; p++) begin
                  nib = hf ? 7 - p : p;
                  pix = int'((rom_mem[a] >> (28 - 4*nib)) & 32'hF);
                  if (pix != 0) img_next[(x + ps*8 + p) & 255] = 4'(pix);
               end
            end
         end
      end
   endtask

   task automatic set_sprite(input int s, input int code, input int attr, input int x, input int y);
      oram[s*4]   = 8'(code);
      oram[s*4+1] = 8'(attr | ((code >> 8) & 1));
      oram[s*4+2] = 8'(x);
      oram[s*4+3] = 8'(y);
   endtask

   task automatic clear_sprites();
      for (int s = 0; s < OBJMAX; s++) set_sprite(s, 0, 0, 0, 8'hF0);
   endtask

   task automatic do_line(input logic [7:0] vd, input int lat, input bit stall);
      bit fl;
      @(negedge clk);
      check("rom_left", exp_rom.size(), 0);
      exp_rom.delete();
      vdump = vd; rom_lat = lat; rom_stall = stall;
      model_line(stall ? 1 : 1000);
      if (stall) foreach (img_next[i]) img_next[i] = 4'd0;
      hs = 1;
      @(negedge clk); hs = 0;
      check("rom_cs_after_hs", int'(rom_cs), 0);
      check("oram_addr_start", int'(oram_addr), 0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check("oram_addr_seq", int'(oram_addr), k);
      end
      fl = 1'($urandom_range(0, 1));
      flip = fl;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); LHBL = 0; hdump = 8'($urandom); pxl_cen = 1; exp_pix.push_back(4'd0);
         @(negedge clk); pxl_cen = 0;
      end
      for (int h = 0; h < 256; h++) begin
         @(negedge clk); LHBL = 1; hdump = 8'(h); pxl_cen = 1;
         exp_pix.push_back(img_cur[fl ? 255 - h : h]);
         @(negedge clk); pxl_cen = 0;
      end
      @(negedge clk); LHBL = 0;
      repeat (650) @(negedge clk);
      if (stall) check("rom_cs_stalled", int'(rom_cs), 1);
      img_cur = img_next;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) rom_mem[i] = $urandom;
      foreach (img_cur[i]) img_cur[i] = 4'd0;
      clear_sprites();
      repeat (4) @(negedge clk);
      check("rst_obj_pxl", int'(obj_pxl), 0);
      check("rst_rom_cs", int'(rom_cs), 0);
      check("rst_oram_addr", int'(oram_addr), 0);
      check("rst_rom_addr", int'(rom_addr), 0);
      rst = 0;
      repeat (300) @(negedge clk);

      do_line(8'h10, 0, 0);
      do_line(8'h10, 1, 0);

      set_sprite(0, 5, 8'h00, 8'h20, 8'h40);
      rom_mem[5*32+0] = 32'h12345678; rom_mem[5*32+1] = 32'h12345678;
      do_line(8'h3F, 2, 0);

      set_sprite(0, 5, 8'hC0, 8'h20, 8'h40);
      rom_mem[5*32+30] = 32'h12345678; rom_mem[5*32+31] = 32'h12345678;
      do_line(8'h3F, 1, 0);

      set_sprite(0, 6, 8'h00, 8'h20, 8'h40);
      set_sprite(1, 7, 8'h00, 8'h24, 8'h40);
      rom_mem[6*32+0] = 32'h33333333; rom_mem[6*32+1] = 32'h33333333;
      rom_mem[7*32+0] = 32'h0F0F0F0F; rom_mem[7*32+1] = 32'h0F0F0F0F;
      do_line(8'h3F, 0, 0);

      clear_sprites();
      set_sprite(0, 5, 8'h00, 8'hF8, 8'h40);
      do_line(8'h3F, 3, 0);

      clear_sprites();
      do_line(8'h10, 0, 0);

      set_sprite(0, 5, 8'h00, 8'h30, 8'h40);
      do_line(8'h3F, 0, 1);

      for (int n = 0; n < 10; n++) begin
         logic [7:0] vd;
         vd = 8'($urandom);
         for (int s = 0; s < OBJMAX; s++) begin
            oram[s*4]   = 8'($urandom);
            oram[s*4+1] = 8'($urandom);
            oram[s*4+2] = 8'($urandom);
            oram[s*4+3] = ($urandom_range(0, 2) == 0) ? vd + 8'd1 - 8'($urandom_range(0, 15))
                                                       : 8'($urandom);
         end
         do_line(vd, $urandom_range(0, 3), 0);
      end

      clear_sprites();
      do_line(8'h10, 0, 0);
      do_line(8'h10, 0, 0);
      repeat (10) @(negedge clk);
      check("pix_left", exp_pix.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
